aoi_response_checker: RTL and testbench

//  Self-checking scoreboard at the response end of the 4-input AOI path.
//  - Stimulus side: accepts {a,b,c,d} vectors and queues golden y = ~((a&b)|(c&d)) in an expectation FIFO.
//  - Response side: compares each observed DUT output against the oldest queued expectation.
//  - Keeps pass/fail counters, a sticky error flag and a first-failure capture, so AOI

---
 rtl/aoi_response_checker.sv | 139 +++++++++++++
 tb/tb_aoi_response_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aoi_response_checker.sv
// Response-side scoreboard for the 4-input AOI path: queues golden results for accepted
// stimulus, compares observed outputs in order, and keeps pass/fail counts plus a
// first-failure capture.
module aoi_response_checker #(
  parameter int unsigned Depth  = 4,
  parameter int unsigned NumVec = 16,
  parameter int unsigned CntW   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stim_valid_i,
  input  logic [3:0]      stim_vec_i,
  output logic            stim_ready_o,
  input  logic            obs_valid_i,
  input  logic            obs_y_i,
  output logic [CntW-1:0] pass_cnt_o,
  output logic [CntW-1:0] fail_cnt_o,
  output logic            err_o,
  output logic            underflow_o,
  output logic [3:0]      first_fail_vec_o,
  output logic [CntW-1:0] first_fail_idx_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [AddrW:0]  wr_ptr_q, rd_ptr_q;
  logic [4:0]      mem_q [Depth];
  logic [CntW-1:0] pushed_q, checked_q, pass_cnt_q, fail_cnt_q, first_fail_idx_q;
  logic [3:0]      first_fail_vec_q;
  logic            err_q, underflow_q;

  logic       empty, full, push, pop, golden_y, match;
  logic [4:0] head;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // FIFO status, handshake and compare decode
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    busy_o       = (state_q == StRun);
    done_o       = (state_q == StDone);
    // Full blocks stimulus even if a pop frees a slot this cycle.
    stim_ready_o = busy_o && !full && (pushed_q < CntW'(NumVec));
    push         = stim_valid_i && stim_ready_o;
    pop          = busy_o && obs_valid_i && !empty;
    golden_y     = ~((stim_vec_i[3] & stim_vec_i[2]) | (stim_vec_i[1] & stim_vec_i[0]));
    head         = mem_q[rd_ptr_q[AddrW-1:0]];
    match        = (head[0] == obs_y_i);
  end

  // Expectation storage: {vector, golden y}; contents need no reset, pointers gate validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= {stim_vec_i, golden_y};
    end
  end

  // Run control, FIFO pointers, counters and first-failure capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      pushed_q         <= '0;
      checked_q        <= '0;
      pass_cnt_q       <= '0;
      fail_cnt_q       <= '0;
      first_fail_idx_q <= '0;
      first_fail_vec_q <= '0;
      err_q            <= 1'b0;
      underflow_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q          <= StRun;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            pushed_q         <= '0;
            checked_q        <= '0;
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            first_fail_idx_q <= '0;
            first_fail_vec_q <= '0;
            err_q            <= 1'b0;
            underflow_q      <= 1'b0;
          end
        end
        StRun: begin
          if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            pushed_q <= sat_inc(pushed_q);
          end
          if (pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            checked_q <= sat_inc(checked_q);
            if (match) begin
              pass_cnt_q <= sat_inc(pass_cnt_q);
            end else begin
              fail_cnt_q <= sat_inc(fail_cnt_q);
              err_q      <= 1'b1;
              if (fail_cnt_q == '0) begin
                first_fail_vec_q <= head[4:1];
                first_fail_idx_q <= checked_q;
              end
            end
          end
          // No bypass: a same-cycle push does not satisfy an observation on an empty FIFO.
          if (obs_valid_i && empty) begin
            underflow_q <= 1'b1;
            err_q       <= 1'b1;
          end
          if (checked_q == CntW'(NumVec)) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pass_cnt_o       = pass_cnt_q;
  assign fail_cnt_o       = fail_cnt_q;
  assign err_o            = err_q;
  assign underflow_o      = underflow_q;
  assign first_fail_vec_o = first_fail_vec_q;
  assign first_fail_idx_o = first_fail_idx_q;

endmodule

// File: tb/tb_aoi_response_checker.sv
// Directed bench for aoi_response_checker with an 8-vector run and a 4-entry FIFO.
module tb_aoi_response_checker;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            stim_valid = 1'b0;
  logic [3:0]      stim_vec = 4'h0;
  logic            stim_ready;
  logic            obs_valid = 1'b0;
  logic            obs_y = 1'b0;
  logic [CntW-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic            err, underflow, busy, done;
  logic [3:0]      first_fail_vec;

  int checks = 0;
  int errors = 0;

  logic [3:0] vecs [8] = '{4'b0000, 4'b0101, 4'b1010, 4'b0010,
                           4'b1100, 4'b0110, 4'b1011, 4'b1111};
  logic       ys   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  aoi_response_checker #(
    .Depth  (4),
    .NumVec (8),
    .CntW   (CntW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .stim_valid_i     (stim_valid),
    .stim_vec_i       (stim_vec),
    .stim_ready_o     (stim_ready),
    .obs_valid_i      (obs_valid),
    .obs_y_i          (obs_y),
    .pass_cnt_o       (pass_cnt),
    .fail_cnt_o       (fail_cnt),
    .err_o            (err),
    .underflow_o      (underflow),
    .first_fail_vec_o (first_fail_vec),
    .first_fail_idx_o (first_fail_idx),
    .busy_o           (busy),
    .done_o           (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, pass the rising edge, sample 1 time unit later, then idle inputs.
  task automatic step(input logic st, input logic sv, input logic [3:0] vec,
                      input logic ov, input logic oy);
    start = st; stim_valid = sv; stim_vec = vec; obs_valid = ov; obs_y = oy;
    @(posedge clk); #1;
    start = 1'b0; stim_valid = 1'b0; stim_vec = 4'h0; obs_valid = 1'b0; obs_y = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // Push vector i while answering vector i-1; fault_idx flips the answer for that comparison.
  task automatic run_vectors(input int fault_idx, input string tag);
    for (int i = 0; i <= 8; i++) begin
      logic oy;
      oy = ys[(i + 7) % 8] ^ ((i - 1) == fault_idx);
      step(1'b0, i < 8, vecs[i % 8], i > 0, oy);
      if (i == 1) check({tag, "_first_pass_latency"}, pass_cnt, 1);
      if (i == 7) check({tag, "_ready_low_at_numvec"}, stim_ready, 0);
    end
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    // 1: reset
    do_reset(2);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_err", err, 0);
    check("rst_underflow", underflow, 0);
    check("rst_ffvec", first_fail_vec, 0);
    check("rst_ffidx", first_fail_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", stim_ready, 0);

    // obs_valid outside RUN is ignored
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    check("idle_obs_underflow", underflow, 0);

    // 2: clean run
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("start_busy", busy, 1);
    check("start_ready", stim_ready, 1);
    run_vectors(-1, "clean");
    check("clean_pass", pass_cnt, 8);
    check("clean_fail", fail_cnt, 0);
    check("clean_err", err, 0);

    // 3: injected fault on 5th comparison (vector 1100)
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("restart_pass_clear", pass_cnt, 0);
    check("restart_done_low", done, 0);
    run_vectors(4, "fault");
    check("fault_pass", pass_cnt, 7);
    check("fault_fail", fail_cnt, 1);
    check("fault_err", err, 1);
    check("fault_ffvec", first_fail_vec, 4'b1100);
    check("fault_ffidx", first_fail_idx, 4);
    check("fault_underflow", underflow, 0);

    // 4: back-pressure with 4-entry FIFO
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("bp_err_clear", err, 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, vecs[k], 1'b0, 1'b0);
    check("bp_full_ready", stim_ready, 0);
    // Pop while full: the offered push must be refused.
    step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    check("bp_ready_after_pop", stim_ready, 1);
    check("bp_pass_after_pop", pass_cnt, 1);
    for (int k = 1; k < 4; k++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    check("bp_drain_pass", pass_cnt, 4);
    check("bp_drain_fail", fail_cnt, 0);
    check("bp_drain_no_underflow", underflow, 0);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    check("bp_no_passthrough", underflow, 1);
    check("bp_no_passthrough_pass", pass_cnt, 4);

    // 5: underflow on the same cycle as first push
    do_reset(1);
    check("rst2_busy", busy, 0);
    check("rst2_underflow", underflow, 0);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0);
    check("uf_underflow", underflow, 1);
    check("uf_err", err, 1);
    check("uf_pass", pass_cnt, 0);
    check("uf_fail", fail_cnt, 0);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    check("uf_entry_held", pass_cnt, 1);
    check("uf_entry_fail", fail_cnt, 0);

    // 6: reset mid-run after 3 pushes, then a clean run
    do_reset(1);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1100, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
    do_reset(1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", stim_ready, 0);
    check("midrst_pass", pass_cnt, 0);
    check("midrst_err", err, 0);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    run_vectors(-1, "post_rst");
    check("post_rst_pass", pass_cnt, 8);
    check("post_rst_fail", fail_cnt, 0);
    check("post_rst_err", err, 0);
    check("post_rst_underflow", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
